csr_access_ctrl: RTL and testbench

//  Writeback-side initiator for the CSR file port. Accepts one CSR-affecting request at a time from the
//  WB stage (csrrd/csrwr/csrxchg/ertn/exception), drives the CSR file strobes for exactly one cycle,

---
 rtl/csr_access_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_csr_access_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_ctrl.sv
// Writeback-side CSR initiator: accepts one request, strobes the CSR file for one cycle,
// then holds a response (old CSR value, flush, redirect target) until the consumer takes it.
module csr_access_ctrl #(
   parameter logic [13:0] CSR_CRMD  = 14'h0,
   parameter logic [13:0] CSR_ECFG  = 14'h4,
   parameter logic [5:0]  ECODE_INT = 6'h0
) (
   input  logic        clk,
   input  logic        rst,
   // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
   // the producer holds valid and payload stable until that edge.
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [13:0] req_csr_num,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_mask,
   input  logic [31:0] req_pc,
   input  logic [31:0] req_vaddr,
   input  logic [5:0]  req_ecode,
   input  logic [8:0]  req_esubcode,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_flush,
   output logic [31:0] resp_target,
   output logic        csr_re,
   output logic [13:0] csr_num,
   input  logic [31:0] csr_rvalue,
   output logic        csr_we,
   output logic [31:0] csr_wmask,
   output logic [31:0] csr_wvalue,
   output logic        wb_ex,
   output logic [5:0]  wb_ecode,
   output logic [8:0]  wb_esubcode,
   output logic [31:0] wb_pc,
   output logic [31:0] wb_vaddr,
   output logic        ertn_flush,
   input  logic [31:0] ex_entry,
   input  logic [31:0] ertn_entry,
   input  logic        has_int,
   output logic [1:0]  dbg_state
);

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_CSRRD = 3'd1;
   localparam logic [2:0] OP_CSRWR = 3'd2;
   localparam logic [2:0] OP_XCHG  = 3'd3;
   localparam logic [2:0] OP_ERTN  = 3'd4;
   localparam logic [2:0] OP_EXC   = 3'd5;

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t      state;
   logic [2:0]  op_q;
   logic [31:0] pc_q;

   logic        op_real;
   logic        int_conv;
   logic [2:0]  eff_op;

   // Ops 6/7 collapse to NOP; a pending interrupt turns any real op into an exception.
   always_comb begin
      op_real  = (req_op >= OP_CSRRD) && (req_op <= OP_EXC);
      int_conv = has_int && op_real;
      eff_op   = OP_NOP;
      if (int_conv)     eff_op = OP_EXC;
      else if (op_real) eff_op = req_op;
   end

   assign dbg_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         op_q        <= OP_NOP;
         pc_q        <= '0;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         resp_flush  <= 1'b0;
         resp_target <= '0;
         csr_re      <= 1'b0;
         csr_num     <= '0;
         csr_we      <= 1'b0;
         csr_wmask   <= '0;
         csr_wvalue  <= '0;
         wb_ex       <= 1'b0;
         wb_ecode    <= '0;
         wb_esubcode <= '0;
         wb_pc       <= '0;
         wb_vaddr    <= '0;
         ertn_flush  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state     <= EXEC;
                  req_ready <= 1'b0;
                  op_q      <= eff_op;
                  pc_q      <= req_pc;
                  csr_num   <= req_csr_num;
                  // Strobes are set here so they are high for exactly the EXEC cycle.
                  case (eff_op)
                     OP_CSRRD: csr_re <= 1'b1;
                     OP_CSRWR: begin
                        csr_re     <= 1'b1;
                        csr_we     <= 1'b1;
                        csr_wmask  <= 32'hFFFF_FFFF;
                        csr_wvalue <= req_wdata;
                     end
                     OP_XCHG: begin
                        csr_re     <= 1'b1;
                        csr_we     <= 1'b1;
                        csr_wmask  <= req_mask;
                        csr_wvalue <= req_wdata;
                     end
                     OP_ERTN: ertn_flush <= 1'b1;
                     OP_EXC: begin
                        wb_ex       <= 1'b1;
                        wb_pc       <= req_pc;
                        wb_ecode    <= int_conv ? ECODE_INT : req_ecode;
                        wb_esubcode <= int_conv ? 9'd0 : req_esubcode;
                        wb_vaddr    <= int_conv ? 32'd0 : req_vaddr;
                     end
                     default: ;
                  endcase
               end
            end
            EXEC: begin
               state       <= RESP;
               resp_valid  <= 1'b1;
               csr_re      <= 1'b0;
               csr_we      <= 1'b0;
               csr_num     <= '0;
               csr_wmask   <= '0;
               csr_wvalue  <= '0;
               wb_ex       <= 1'b0;
               wb_ecode    <= '0;
               wb_esubcode <= '0;
               wb_pc       <= '0;
               wb_vaddr    <= '0;
               ertn_flush  <= 1'b0;
               resp_rdata  <= '0;
               resp_flush  <= 1'b0;
               resp_target <= '0;
               case (op_q)
                  OP_CSRRD: resp_rdata <= csr_rvalue;
                  OP_CSRWR, OP_XCHG: begin
                     // csr_rvalue is the pre-write value during the strobe cycle.
                     resp_rdata <= csr_rvalue;
                     if (csr_num == CSR_CRMD || csr_num == CSR_ECFG) begin
                        resp_flush  <= 1'b1;
                        resp_target <= pc_q + 32'd4;
                     end
                  end
                  OP_ERTN: begin
                     resp_flush  <= 1'b1;
                     resp_target <= ertn_entry;
                  end
                  OP_EXC: begin
                     resp_flush  <= 1'b1;
                     resp_target <= ex_entry;
                  end
                  default: ;
               endcase
            end
            RESP: begin
               if (resp_ready) begin
                  state       <= IDLE;
                  req_ready   <= 1'b1;
                  resp_valid  <= 1'b0;
                  resp_rdata  <= '0;
                  resp_flush  <= 1'b0;
                  resp_target <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl: hand-computed strobes, responses, flushes and reset behaviour.
module tb_csr_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = '0;
   logic [13:0] req_csr_num = '0;
   logic [31:0] req_wdata = '0, req_mask = '0, req_pc = '0, req_vaddr = '0;
   logic [5:0]  req_ecode = '0;
   logic [8:0]  req_esubcode = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata, resp_target;
   logic        resp_flush;
   logic        csr_re, csr_we;
   logic [13:0] csr_num;
   logic [31:0] csr_rvalue = '0;
   logic [31:0] csr_wmask, csr_wvalue;
   logic        wb_ex;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_pc, wb_vaddr;
   logic        ertn_flush;
   logic [31:0] ex_entry = 32'h1C00_8000;
   logic [31:0] ertn_entry = 32'h1C00_0400;
   logic        has_int = 1'b0;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   int n_re = 0, n_we = 0, n_ex = 0, n_ertn = 0;
   logic [31:0] exp_q[$];

   csr_access_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_csr_num(req_csr_num), .req_wdata(req_wdata), .req_mask(req_mask),
      .req_pc(req_pc), .req_vaddr(req_vaddr), .req_ecode(req_ecode),
      .req_esubcode(req_esubcode),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_flush(resp_flush), .resp_target(resp_target),
      .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
      .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
      .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
      .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush),
      .ex_entry(ex_entry), .ertn_entry(ertn_entry), .has_int(has_int),
      .dbg_state(dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // strobe pulse counters, sampled away from the active edge
   always @(negedge clk) begin
      if (csr_re)     n_re++;
      if (csr_we)     n_we++;
      if (wb_ex)      n_ex++;
      if (ertn_flush) n_ertn++;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents one request at a negedge; returns at the negedge of the strobe cycle.
   task automatic issue(input logic [2:0] op, input logic [13:0] num, input logic [31:0] wdata,
                        input logic [31:0] mask, input logic [31:0] pc, input logic [31:0] vaddr,
                        input logic [5:0] ecode, input logic [8:0] esub, input logic hint);
      @(negedge clk);
      n_re = 0; n_we = 0; n_ex = 0; n_ertn = 0;
      check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_op = op; req_csr_num = num; req_wdata = wdata; req_mask = mask;
      req_pc = pc; req_vaddr = vaddr; req_ecode = ecode; req_esubcode = esub;
      has_int = hint; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; has_int = 1'b0; req_op = '0;
   endtask

   task automatic check_resp(input string tag, input logic flush, input logic [31:0] target);
      logic [31:0] exp_rdata;
      exp_rdata = exp_q.pop_front();
      check_eq({tag, "_valid"},  {31'd0, resp_valid}, 32'd1);
      check_eq({tag, "_rdata"},  resp_rdata, exp_rdata);
      check_eq({tag, "_flush"},  {31'd0, resp_flush}, {31'd0, flush});
      check_eq({tag, "_target"}, resp_target, target);
   endtask

   task automatic finish_resp(input string tag);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check_eq({tag, "_valid_drop"}, {31'd0, resp_valid}, 32'd0);
      check_eq({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
   endtask

   task automatic check_counts(input string tag, input int re, input int we, input int ex, input int er);
      check_eq({tag, "_n_re"},   n_re,   re);
      check_eq({tag, "_n_we"},   n_we,   we);
      check_eq({tag, "_n_ex"},   n_ex,   ex);
      check_eq({tag, "_n_ertn"}, n_ertn, er);
   endtask

   initial begin
      // reset
      repeat (3) @(negedge clk);
      check_eq("rst_req_ready",  {31'd0, req_ready},  32'd1);
      check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check_eq("rst_strobes",    {28'd0, csr_re, csr_we, wb_ex, ertn_flush}, 32'd0);
      rst = 1'b0;

      // CSRRD 0x30 reading 0x1234
      csr_rvalue = 32'h0000_1234;
      exp_q.push_back(32'h0000_1234);
      issue(3'd1, 14'h30, 32'h0, 32'h0, 32'h1C00_0000, 32'h0, 6'h0, 9'h0, 1'b0);
      check_eq("rd_re",  {31'd0, csr_re}, 32'd1);
      check_eq("rd_we",  {31'd0, csr_we}, 32'd0);
      check_eq("rd_num", {18'd0, csr_num}, 32'h30);
      @(negedge clk);
      check_eq("rd_re_off", {31'd0, csr_re}, 32'd0);
      check_resp("rd", 1'b0, 32'h0);
      finish_resp("rd");
      check_counts("rd", 1, 0, 0, 0);

      // CSRXCHG to CRMD: masked write, refetch flush at pc+4, old value returned
      csr_rvalue = 32'h0000_00AB;
      exp_q.push_back(32'h0000_00AB);
      issue(3'd3, 14'h0, 32'h4, 32'h4, 32'h1C00_0100, 32'h0, 6'h0, 9'h0, 1'b0);
      check_eq("xchg_we",     {31'd0, csr_we}, 32'd1);
      check_eq("xchg_wmask",  csr_wmask, 32'h4);
      check_eq("xchg_wvalue", csr_wvalue, 32'h4);
      @(negedge clk);
      check_eq("xchg_wmask_off", csr_wmask, 32'h0);
      check_resp("xchg", 1'b1, 32'h1C00_0104);
      finish_resp("xchg");
      check_counts("xchg", 1, 1, 0, 0);

      // CSRWR to a non-flushing CSR: full mask, no redirect
      csr_rvalue = 32'hDEAD_BEEF;
      exp_q.push_back(32'hDEAD_BEEF);
      issue(3'd2, 14'h5, 32'h55AA_0F0F, 32'h1, 32'h1C00_0180, 32'h0, 6'h0, 9'h0, 1'b0);
      check_eq("wr_wmask",  csr_wmask, 32'hFFFF_FFFF);
      check_eq("wr_wvalue", csr_wvalue, 32'h55AA_0F0F);
      @(negedge clk);
      check_resp("wr", 1'b0, 32'h0);
      finish_resp("wr");

      // CSRWR to ECFG at the top of the address space: target wraps to 0
      csr_rvalue = 32'h0000_0077;
      exp_q.push_back(32'h0000_0077);
      issue(3'd2, 14'h4, 32'h1, 32'h0, 32'hFFFF_FFFC, 32'h0, 6'h0, 9'h0, 1'b0);
      @(negedge clk);
      check_resp("wrap", 1'b1, 32'h0);
      finish_resp("wrap");

      // EXC without interrupt
      exp_q.push_back(32'h0);
      issue(3'd5, 14'h0, 32'h0, 32'h0, 32'h1C00_0200, 32'h3, 6'h9, 9'h5, 1'b0);
      check_eq("exc_wb_ex",    {31'd0, wb_ex}, 32'd1);
      check_eq("exc_ecode",    {26'd0, wb_ecode}, 32'h9);
      check_eq("exc_esub",     {23'd0, wb_esubcode}, 32'h5);
      check_eq("exc_vaddr",    wb_vaddr, 32'h3);
      check_eq("exc_pc",       wb_pc, 32'h1C00_0200);
      check_eq("exc_re",       {31'd0, csr_re}, 32'd0);
      @(negedge clk);
      check_eq("exc_ecode_off", {26'd0, wb_ecode}, 32'h0);
      check_resp("exc", 1'b1, 32'h1C00_8000);
      finish_resp("exc");
      check_counts("exc", 0, 0, 1, 0);

      // CSRWR with pending interrupt becomes an interrupt exception
      exp_q.push_back(32'h0);
      issue(3'd2, 14'h4, 32'h1, 32'h0, 32'h1C00_0300, 32'h77, 6'h3, 9'h2, 1'b1);
      check_eq("int_wb_ex",  {31'd0, wb_ex}, 32'd1);
      check_eq("int_ecode",  {26'd0, wb_ecode}, 32'h0);
      check_eq("int_vaddr",  wb_vaddr, 32'h0);
      check_eq("int_pc",     wb_pc, 32'h1C00_0300);
      @(negedge clk);
      check_resp("int", 1'b1, 32'h1C00_8000);
      finish_resp("int");
      check_counts("int", 0, 0, 1, 0);

      // NOP with pending interrupt: no conversion, no CSR activity
      exp_q.push_back(32'h0);
      issue(3'd0, 14'h4, 32'h1, 32'h1, 32'h1C00_0500, 32'h0, 6'h0, 9'h0, 1'b1);
      @(negedge clk);
      check_resp("nop", 1'b0, 32'h0);
      finish_resp("nop");
      check_counts("nop", 0, 0, 0, 0);

      // ERTN at pc 0xFFFFFFFC with resp_ready held low for 5 cycles
      exp_q.push_back(32'h0);
      issue(3'd4, 14'h0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 6'h0, 9'h0, 1'b0);
      check_eq("ertn_strobe", {31'd0, ertn_flush}, 32'd1);
      req_op = 3'd1; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("hold_valid",  {31'd0, resp_valid}, 32'd1);
         check_eq("hold_ready",  {31'd0, req_ready}, 32'd0);
         check_eq("hold_flush",  {31'd0, resp_flush}, 32'd1);
         check_eq("hold_target", resp_target, 32'h1C00_0400);
      end
      req_valid = 1'b0; req_op = 3'd0;
      check_resp("ertn", 1'b1, 32'h1C00_0400);
      finish_resp("ertn");
      check_counts("ertn", 0, 0, 0, 1);

      // reset during the strobe cycle drops the request
      issue(3'd2, 14'h0, 32'hF, 32'h0, 32'h1C00_0600, 32'h0, 6'h0, 9'h0, 1'b0);
      check_eq("rst_exec_we", {31'd0, csr_we}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check_eq("rst_exec_we_drop",  {31'd0, csr_we}, 32'd0);
      check_eq("rst_exec_num_drop", {18'd0, csr_num}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      check_eq("rst_exec_ready", {31'd0, req_ready}, 32'd1);
      repeat (3) @(negedge clk);
      check_eq("rst_exec_resp", {31'd0, resp_valid}, 32'd0);
      check_counts("rst_exec", 1, 1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
